// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions for the core's memory port: region bases,
// region/state enums and the combinational address decoder.
package mem_map_pkg;

  localparam logic [31:0] DEF_ROM_BASE  = 32'h0040_0000;
  localparam logic [31:0] DEF_RAM_BASE  = 32'h1001_0000;
  localparam logic [31:0] DEF_GPIO_ADDR = 32'h1002_0000;

  typedef enum logic [1:0] {
    REG_ROM,
    REG_RAM,
    REG_GPIO,
    REG_NONE
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } rsp_state_t;

  // Offsets are unsigned, so an address below a base wraps high and misses.
  function automatic region_t decode_region(
    input logic [31:0] addr,
    input logic [31:0] rom_base,
    input int unsigned rom_words,
    input logic [31:0] ram_base,
    input int unsigned ram_words,
    input logic [31:0] gpio_addr
  );
    logic [31:0] rom_off;
    logic [31:0] ram_off;
    rom_off = addr - rom_base;
    ram_off = addr - ram_base;
    if (rom_off < (32'(rom_words) << 2))
      return REG_ROM;
    else if (ram_off < (32'(ram_words) << 2))
      return REG_RAM;
    else if (addr == gpio_addr)
      return REG_GPIO;
    else
      return REG_NONE;
  endfunction

  // Fixed instruction image: upper half tags the ROM, lower half is the word index.
  function automatic logic [31:0] rom_init_word(input int unsigned idx);
    logic [15:0] low;
    low = idx[15:0];
    return {16'hC0DE, low};
  endfunction

endpackage

// File: rtl/word_ram.sv
// Word-wide storage with synchronous write and asynchronous read; the ROM
// variant is a constant table fixed at elaboration and ignores writes.
module word_ram
  import mem_map_pkg::*;
#(
  parameter  int WORDS    = 64,
  parameter  bit ROM_INIT = 1'b0,
  localparam int IW       = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  generate
    if (ROM_INIT) begin : g_rom
      logic [31:0] table_w [WORDS];
      logic        unused_wr;

      for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        assign table_w[gi] = rom_init_word(gi);
      end

      assign rdata     = table_w[addr];
      assign unused_wr = ^{clk, we, wdata};
    end else begin : g_ram
      logic [31:0] mem [WORDS];

      always_ff @(posedge clk) begin
        if (we)
          mem[addr] <= wdata;
      end

      assign rdata = mem[addr];
    end
  endgenerate

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: one request at a time, ROM/RAM/GPIO decode,
// programmable wait states and a one-cycle response strobe.
module mem_bus_responder
  import mem_map_pkg::*;
#(
  parameter  int          WAIT_CYCLES = 1,
  parameter  int          ROM_WORDS   = 64,
  parameter  int          RAM_WORDS   = 64,
  parameter  logic [31:0] ROM_BASE    = DEF_ROM_BASE,
  parameter  logic [31:0] RAM_BASE    = DEF_RAM_BASE,
  parameter  logic [31:0] GPIO_ADDR   = DEF_GPIO_ADDR,
  localparam int          CW          = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1,
  localparam int          IWR         = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1,
  localparam int          IWA         = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] gpio_out
);

  rsp_state_t    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [31:0]   addr_reg;
  logic          we_reg;
  logic [31:0]   wdata_reg;

  logic [31:0]   sel_addr;
  logic          sel_we;
  region_t       region;
  logic          err_c;
  logic [31:0]   rdata_c;
  logic [IWR-1:0] rom_idx;
  logic [IWA-1:0] ram_idx;
  logic [31:0]   rom_rdata;
  logic [31:0]   ram_rdata;
  logic          ram_we;

  // In IDLE the live request is decoded so a zero-wait build can answer at once.
  assign sel_addr = (state_reg == ST_IDLE) ? req_addr : addr_reg;
  assign sel_we   = (state_reg == ST_IDLE) ? req_we   : we_reg;

  assign region = decode_region(sel_addr, ROM_BASE, ROM_WORDS, RAM_BASE, RAM_WORDS, GPIO_ADDR);
  assign err_c  = (sel_addr[1:0] != 2'b00) || (region == REG_NONE) ||
                  ((region == REG_ROM) && sel_we);

  assign rom_idx = IWR'((sel_addr - ROM_BASE) >> 2);
  assign ram_idx = IWA'((sel_addr - RAM_BASE) >> 2);

  // Stores land only on the edge that leaves RESP, so a reset before then drops them.
  assign ram_we = (state_reg == ST_RESP) && we_reg && !err_c && (region == REG_RAM);

  word_ram #(
    .WORDS    (ROM_WORDS),
    .ROM_INIT (1'b1)
  ) u_rom (
    .clk   (clk),
    .we    (1'b0),
    .addr  (rom_idx),
    .wdata (32'h0),
    .rdata (rom_rdata)
  );

  word_ram #(
    .WORDS    (RAM_WORDS),
    .ROM_INIT (1'b0)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_idx),
    .wdata (wdata_reg),
    .rdata (ram_rdata)
  );

  always_comb begin
    rdata_c = '0;
    if (!err_c && !sel_we) begin
      case (region)
        REG_ROM:  rdata_c = rom_rdata;
        REG_RAM:  rdata_c = ram_rdata;
        REG_GPIO: rdata_c = gpio_out;
        default:  rdata_c = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      gpio_out  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            addr_reg  <= req_addr;
            we_reg    <= req_we;
            wdata_reg <= req_wdata;
            cnt_reg   <= CW'(WAIT_CYCLES);
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_reg <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rdata_c;
              rsp_err   <= err_c;
            end else begin
              state_reg <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_reg <= CW'(1)) begin
            state_reg <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_c;
            rsp_err   <= err_c;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        ST_RESP: begin
          if (we_reg && !err_c && (region == REG_GPIO))
            gpio_out <= wdata_reg;
          state_reg <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state_reg <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
